// File: rtl/conv_psum_accumulator.sv
// ---------------------------------------------------------------------------
// conv_psum_accumulator
//   Channel-group partial-sum accumulator and output post-processor that sits
//   after the last conv unit of the systolic chain. Each of the N_KERNEL lanes
//   sums cfg_n_grp+1 partial sums. The total is then requantised with a
//   rounding arithmetic right shift, optionally clamped by ReLU, and
//   saturated or truncated to B_OUT bits. The result is queued in a small
//   output FIFO that uses valid/ready handshaking.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   cfg_we, cfg_*      config load (ignored while busy; this sets cfg_err)
//   in_valid/in_ready  partial-sum input handshake, in_psum lane k at
//                      [k*B_PSUM +: B_PSUM]
//   out_valid/out_ready/out_data  FIFO head, lane k at [k*B_OUT +: B_OUT]
//   busy               a group is partially accumulated
//   flag_clr           clears the sticky ovf / cfg_err flags
//   ovf                sticky: an emitted lane differed from its rounded value
//   cfg_err            sticky: config write attempted mid-group
// ---------------------------------------------------------------------------

// Per-lane accumulator plus post-processing datapath.
//   clk, rst    clock / synchronous reset
//   accept      an input beat is consumed this cycle
//   final_acc   this beat closes the group: emit the sum and clear acc
//   psum        signed partial sum for this lane
//   shift/relu/sat  active requantisation settings
//   res         post-processed B_OUT result, valid when final_acc is high
//   altered     res differs from the rounded (post-ReLU) value
module conv_psum_lane #(
    parameter int B_PSUM = 32,
    parameter int B_CNT  = 8,
    parameter int B_OUT  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     accept,
    input  logic                     final_acc,
    input  logic signed [B_PSUM-1:0] psum,
    input  logic [4:0]               shift,
    input  logic                     relu,
    input  logic                     sat,
    output logic [B_OUT-1:0]         res,
    output logic                     altered
);
    localparam int B_ACC = B_PSUM + B_CNT;
    localparam int B_EXT = B_ACC + 1;

    // Clamp bounds expressed in the extended width.
    localparam logic signed [B_EXT-1:0] MAXV = {{(B_EXT-B_OUT+1){1'b0}}, {(B_OUT-1){1'b1}}};
    localparam logic signed [B_EXT-1:0] MINV = {{(B_EXT-B_OUT+1){1'b1}}, {(B_OUT-1){1'b0}}};

    logic signed [B_ACC-1:0] acc;
    logic signed [B_EXT-1:0] sum, rnd, r, rr, clip;

    always_comb begin
        sum = B_EXT'(acc) + B_EXT'(psum);
        // Add half an LSB of the shifted result so that the shift rounds half-up.
        rnd = (shift == 5'd0) ? '0 : (B_EXT'(1) <<< (shift - 5'd1));
        r   = (sum + rnd) >>> shift;
        rr  = (relu && (r < 0)) ? '0 : r;
        if (rr > MAXV)      clip = MAXV;
        else if (rr < MINV) clip = MINV;
        else                clip = rr;
        res     = sat ? clip[B_OUT-1:0] : rr[B_OUT-1:0];
        altered = ({{(B_EXT-B_OUT){res[B_OUT-1]}}, res} != rr);
    end

    always_ff @(posedge clk) begin
        if (rst)            acc <= '0;
        else if (accept) begin
            if (final_acc)  acc <= '0;
            else            acc <= acc + B_ACC'(psum);
        end
    end
endmodule

module conv_psum_accumulator #(
    parameter int N_KERNEL   = 4,
    parameter int B_PSUM     = 32,
    parameter int B_CNT      = 8,
    parameter int B_OUT      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [B_CNT-1:0]             cfg_n_grp,
    input  logic [4:0]                   cfg_shift,
    input  logic                         cfg_relu,
    input  logic                         cfg_sat,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_KERNEL*B_PSUM-1:0]   in_psum,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_KERNEL*B_OUT-1:0]    out_data,
    output logic                         busy,
    input  logic                         flag_clr,
    output logic                         ovf,
    output logic                         cfg_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = N_KERNEL * B_OUT;

    typedef struct packed {
        logic [B_CNT-1:0] n_grp;
        logic [4:0]       shift;
        logic             relu;
        logic             sat;
    } cfg_t;

    cfg_t                          cfg;
    logic [B_CNT-1:0]              grp_cnt;
    logic [FIFO_DEPTH-1:0][DW-1:0] mem;
    logic [PW-1:0]                 rd_ptr, wr_ptr;
    logic [CW-1:0]                 count;

    logic accept, final_acc, push, pop;
    logic [N_KERNEL-1:0][B_OUT-1:0] lane_res;
    logic [N_KERNEL-1:0]            lane_alt;

    // Ready depends only on FIFO space. This is pessimistic for non-final
    // beats, but it keeps in_ready free of any path from grp_cnt.
    assign in_ready  = !rst && (count < CW'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;
    assign final_acc = accept && (grp_cnt == cfg.n_grp);
    assign push      = final_acc;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign busy      = (grp_cnt != '0);

    genvar k;
    generate
        for (k = 0; k < N_KERNEL; k++) begin : g_lane
            conv_psum_lane #(
                .B_PSUM (B_PSUM),
                .B_CNT  (B_CNT),
                .B_OUT  (B_OUT)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .accept    (accept),
                .final_acc (final_acc),
                .psum      (in_psum[k*B_PSUM +: B_PSUM]),
                .shift     (cfg.shift),
                .relu      (cfg.relu),
                .sat       (cfg.sat),
                .res       (lane_res[k]),
                .altered   (lane_alt[k])
            );
        end
    endgenerate

    // Config registers. A write is accepted only between groups.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg.n_grp <= '0;
            cfg.shift <= '0;
            cfg.relu  <= 1'b0;
            cfg.sat   <= 1'b1;
        end else if (cfg_we && !busy) begin
            cfg.n_grp <= cfg_n_grp;
            cfg.shift <= cfg_shift;
            cfg.relu  <= cfg_relu;
            cfg.sat   <= cfg_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)            grp_cnt <= '0;
        else if (accept)    grp_cnt <= final_acc ? '0 : grp_cnt + 1'b1;
    end

    // Sticky flags. A set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf     <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            if (flag_clr) begin
                ovf     <= 1'b0;
                cfg_err <= 1'b0;
            end
            if (push && (|lane_alt)) ovf     <= 1'b1;
            if (cfg_we && busy)      cfg_err <= 1'b1;
        end
    end

    // Output FIFO. Pointers wrap naturally through their PW-bit width.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= lane_res;
    end
endmodule

// File: tb/tb_conv_psum_accumulator.sv
module tb_conv_psum_accumulator;
    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_we;
    logic [7:0]   cfg_n_grp;
    logic [4:0]   cfg_shift;
    logic         cfg_relu, cfg_sat;
    logic         in_valid, in_ready;
    logic [127:0] in_psum;
    logic         out_valid, out_ready;
    logic [63:0]  out_data;
    logic         busy, flag_clr, ovf, cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    conv_psum_accumulator #(
        .N_KERNEL(4), .B_PSUM(32), .B_CNT(8), .B_OUT(16), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_n_grp(cfg_n_grp),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .cfg_sat(cfg_sat),
        .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .flag_clr(flag_clr), .ovf(ovf), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pk(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [63:0] po(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_cfg(input logic [7:0] n, input logic [4:0] sh, input logic rl, input logic st);
        cfg_we = 1; cfg_n_grp = n; cfg_shift = sh; cfg_relu = rl; cfg_sat = st;
        tick();
        cfg_we = 0;
    endtask

    // Presents one beat. Waits a bounded number of cycles for in_ready.
    task automatic send(input logic [127:0] d);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin tick(); w++; end
        n_cmp++;
        if (!in_ready) begin n_bad++; $display("FAIL send_ready: got in_ready=%b want 1", in_ready); end
        in_valid = 1; in_psum = d;
        tick();
        in_valid = 0;
    endtask

    task automatic pop_one();
        out_ready = 1; tick(); out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; tick(); tick();
        n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (ovf !== 1'b0 || cfg_err !== 1'b0) begin n_bad++; $display("FAIL rst_flags: got ovf=%b cfg_err=%b want 0 0", ovf, cfg_err); end
        rst = 0; tick();
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        do_cfg(8'd2, 5'd0, 1'b0, 1'b1);
        send(pk(1, 2, 3, 4));
        send(pk(1, 2, 3, 4));
        n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_mid: got busy=%b out_valid=%b want 1 0", busy, out_valid); end
        send(pk(1, 2, 3, 4));
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== po(3, 6, 9, 12)) begin n_bad++; $display("FAIL basic_data: got %h want %h", out_data, po(3, 6, 9, 12)); end
        n_cmp++; if (busy !== 1'b0 || ovf !== 1'b0) begin n_bad++; $display("FAIL basic_busy_ovf: got busy=%b ovf=%b want 0 0", busy, ovf); end
        pop_one();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pop: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_requant();
        // 6+2>>2=2, -6+2>>>2=-1 -> relu 0, 5+2>>2=1, 0x7FFFF+2>>2=0x20000 -> sat 0x7FFF
        do_cfg(8'd0, 5'd2, 1'b1, 1'b1);
        send(pk(6, -6, 5, 32'h0007FFFF));
        n_cmp++; if (out_valid !== 1'b1 || out_data !== po(2, 0, 1, 16'h7FFF)) begin n_bad++; $display("FAIL requant_data: got v=%b %h want 1 %h", out_valid, out_data, po(2, 0, 1, 16'h7FFF)); end
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL requant_ovf: got %b want 1", ovf); end
        pop_one();
        // Negative saturation with half-up rounding: -7+2>>>2 = -2, -0x40000>>>2 = -0x10000 -> -32768
        do_cfg(8'd0, 5'd2, 1'b0, 1'b1);
        send(pk(-7, 32'hFFFC0000, -2, 10));
        n_cmp++; if (out_data !== po(16'hFFFE, 16'h8000, 16'h0000, 16'h0003)) begin n_bad++; $display("FAIL requant_neg: got %h want %h", out_data, po(16'hFFFE, 16'h8000, 16'h0000, 16'h0003)); end
        pop_one();
    endtask

    task automatic test_truncate();
        flag_clr = 1; tick(); flag_clr = 0;
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL trunc_preclr: got ovf=%b want 0", ovf); end
        do_cfg(8'd0, 5'd0, 1'b0, 1'b0);
        send(pk(32'h00012345, 32'hFFFFFFFF, 0, 7));
        n_cmp++; if (out_data !== po(16'h2345, 16'hFFFF, 0, 7)) begin n_bad++; $display("FAIL trunc_data: got %h want %h", out_data, po(16'h2345, 16'hFFFF, 0, 7)); end
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL trunc_ovf: got %b want 1", ovf); end
        flag_clr = 1; tick(); flag_clr = 0;
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL trunc_clr: got ovf=%b want 0", ovf); end
        pop_one();
    endtask

    task automatic test_back_pressure();
        int acc_n;
        acc_n = 0;
        do_cfg(8'd0, 5'd0, 1'b0, 1'b1);
        out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_psum = pk(100 + i, i, 0, 0);
            if (in_ready) acc_n++;
            tick();
        end
        in_valid = 0;
        n_cmp++; if (acc_n !== 4) begin n_bad++; $display("FAIL bp_accepted: got %0d want 4", acc_n); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== po(16'(100 + i), 16'(i), 0, 0)) begin
                n_bad++; $display("FAIL bp_drain%0d: got v=%b %h want 1 %h", i, out_valid, out_data, po(16'(100 + i), 16'(i), 0, 0));
            end
            tick();
            if (i == 0) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_return: got %b want 1", in_ready); end
            end
        end
        out_ready = 0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
        // Refill, then push and pop in the same cycle.
        send(pk(200, 0, 0, 0));
        send(pk(201, 0, 0, 0));
        in_valid = 1; in_psum = pk(202, 0, 0, 0); out_ready = 1;
        n_cmp++; if (out_data !== po(200, 0, 0, 0)) begin n_bad++; $display("FAIL bp_sim_head: got %h want %h", out_data, po(200, 0, 0, 0)); end
        tick();
        in_valid = 0;
        n_cmp++; if (out_data !== po(201, 0, 0, 0)) begin n_bad++; $display("FAIL bp_sim_next: got %h want %h", out_data, po(201, 0, 0, 0)); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== po(202, 0, 0, 0)) begin n_bad++; $display("FAIL bp_sim_last: got v=%b %h want 1 %h", out_valid, out_data, po(202, 0, 0, 0)); end
        tick();
        out_ready = 0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_sim_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_cfg_guard();
        do_cfg(8'd3, 5'd0, 1'b0, 1'b1);
        send(pk(1, 1, 1, 1));
        do_cfg(8'd0, 5'd0, 1'b0, 1'b1);
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL guard_err: got %b want 1", cfg_err); end
        send(pk(1, 1, 1, 1));
        send(pk(1, 1, 1, 1));
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL guard_early: got out_valid=%b want 0", out_valid); end
        send(pk(1, 1, 1, 1));
        n_cmp++; if (out_valid !== 1'b1 || out_data !== po(4, 4, 4, 4)) begin n_bad++; $display("FAIL guard_out: got v=%b %h want 1 %h", out_valid, out_data, po(4, 4, 4, 4)); end
        pop_one();
        // Idle write takes effect. A set and a clear in the same cycle leave the flag set.
        do_cfg(8'd1, 5'd0, 1'b0, 1'b1);
        send(pk(5, 6, 7, 8));
        flag_clr = 1;
        do_cfg(8'd0, 5'd0, 1'b0, 1'b1);
        flag_clr = 0;
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL guard_set_wins: got %b want 1", cfg_err); end
        send(pk(5, 6, 7, 8));
        n_cmp++; if (out_valid !== 1'b1 || out_data !== po(10, 12, 14, 16)) begin n_bad++; $display("FAIL guard_idle_cfg: got v=%b %h want 1 %h", out_valid, out_data, po(10, 12, 14, 16)); end
        pop_one();
        flag_clr = 1; tick(); flag_clr = 0;
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL guard_clr: got %b want 0", cfg_err); end
    endtask

    task automatic test_reset_mid();
        do_cfg(8'd2, 5'd0, 1'b0, 1'b1);
        out_ready = 0;
        for (int i = 0; i < 8; i++) send(pk(9, 9, 9, 9));
        n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_pre: got busy=%b v=%b want 1 1", busy, out_valid); end
        rst = 1; tick();
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_rst: got v=%b busy=%b rdy=%b want 0 0 0", out_valid, busy, in_ready); end
        rst = 0; tick();
        do_cfg(8'd2, 5'd0, 1'b0, 1'b1);
        send(pk(7, 0, -1, 2));
        send(pk(7, 0, -1, 2));
        send(pk(7, 0, -1, 2));
        n_cmp++; if (out_valid !== 1'b1 || out_data !== po(21, 0, 16'hFFFD, 6)) begin n_bad++; $display("FAIL rmid_sum: got v=%b %h want 1 %h", out_valid, out_data, po(21, 0, 16'hFFFD, 6)); end
        pop_one();
    endtask

    initial begin
        rst = 1; cfg_we = 0; cfg_n_grp = 0; cfg_shift = 0; cfg_relu = 0; cfg_sat = 1;
        in_valid = 0; in_psum = '0; out_ready = 0; flag_clr = 0;
        test_reset();
        test_basic();
        test_requant();
        test_truncate();
        test_back_pressure();
        test_cfg_guard();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
